// File: rtl/taillight_pkg.sv
// Shared encodings for the tail-light command front end and LED sequencers:
// 2-bit mode codes, the arbiter FSM state enum and a state-to-mode helper.
package taillight_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_OFF    = 2'b00;
    localparam mode_t MODE_LEFT   = 2'b01;
    localparam mode_t MODE_RIGHT  = 2'b10;
    localparam mode_t MODE_HAZARD = 2'b11;

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_LEFT   = 3'd1,
        ST_RIGHT  = 3'd2,
        ST_HAZARD = 3'd3,
        ST_GAP    = 3'd4
    } state_t;

    // GAP is a forced-off interval, so it reports the OFF mode code
    function automatic mode_t state_mode(input state_t st);
        mode_t m;
        case (st)
            ST_LEFT:   m = MODE_LEFT;
            ST_RIGHT:  m = MODE_RIGHT;
            ST_HAZARD: m = MODE_HAZARD;
            default:   m = MODE_OFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/turn_signal_ctrl_if.sv
// Switch-side inputs and sequencer-side outputs of the turn signal controller.
// The controller uses the master modport; the board/sequencer side uses slave.
interface turn_signal_ctrl_if;
    import taillight_pkg::*;

    logic  sw_left;
    logic  sw_right;
    logic  sw_hazard;
    logic  left_ena;
    logic  right_ena;
    mode_t mode;
    logic  conflict;

    modport master (
        input  sw_left, sw_right, sw_hazard,
        output left_ena, right_ena, mode, conflict
    );

    modport slave (
        output sw_left, sw_right, sw_hazard,
        input  left_ena, right_ena, mode, conflict
    );

endinterface

// File: rtl/turn_signal_ctrl_debounce.sv
// sw_debounce: 2-flop synchronizer followed by a counter debouncer that accepts
// a new level only after DEBOUNCE_CYCLES consecutive differing samples.
module sw_debounce #(
    parameter int DEBOUNCE_CYCLES = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic clean
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_r;
    logic             sync2_r;
    logic             clean_r;
    logic [CNT_W-1:0] cnt_r;

    // Two-stage synchronizer for the asynchronous switch input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
        end
    end

    // Count differing samples; the edge that completes the run adopts the new level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= '0;
            clean_r <= 1'b0;
        end else if (sync2_r == clean_r) begin
            cnt_r   <= '0;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r   <= '0;
            clean_r <= sync2_r;
        end else begin
            cnt_r   <= cnt_r + CNT_ONE;
        end
    end

    assign clean = clean_r;

endmodule

// File: rtl/turn_signal_ctrl.sv
// turn_signal_ctrl: debounces the three driver switches and arbitrates them into
// left/right sequencer enables, inserting a forced all-off gap on mode changes.
module turn_signal_ctrl
    import taillight_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int MIN_OFF         = 2
) (
    input logic                clk,
    input logic                rst_n,
    turn_signal_ctrl_if.master bus
);

    localparam int             GAP_W    = $clog2(MIN_OFF + 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_OFF - 1);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

    logic             left_db_s;
    logic             right_db_s;
    logic             hazard_db_s;
    logic             conflict_s;
    state_t           req_s;
    state_t           state_r;
    state_t           next_state_s;
    logic [GAP_W-1:0] gap_cnt_r;
    logic [GAP_W-1:0] gap_cnt_next_s;
    logic             left_ena_r;
    logic             right_ena_r;
    mode_t            mode_r;
    logic             conflict_r;

    sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (bus.sw_left),
        .clean (left_db_s)
    );

    sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (bus.sw_right),
        .clean (right_db_s)
    );

    sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_hazard (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (bus.sw_hazard),
        .clean (hazard_db_s)
    );

    // Priority request decode: hazard wins, opposing turn requests cancel out
    always_comb begin
        req_s      = ST_OFF;
        conflict_s = 1'b0;
        if (hazard_db_s) begin
            req_s = ST_HAZARD;
        end else if (left_db_s && right_db_s) begin
            conflict_s = 1'b1;
        end else if (left_db_s) begin
            req_s = ST_LEFT;
        end else if (right_db_s) begin
            req_s = ST_RIGHT;
        end else begin
            req_s = ST_OFF;
        end
    end

    // Next-state logic; the gap counter only loads on leaving an active mode
    always_comb begin
        next_state_s   = state_r;
        gap_cnt_next_s = gap_cnt_r;
        case (state_r)
            ST_OFF: begin
                if (req_s != ST_OFF) begin
                    next_state_s = req_s;
                end else begin
                    next_state_s = ST_OFF;
                end
            end
            ST_LEFT, ST_RIGHT, ST_HAZARD: begin
                if (req_s == state_r) begin
                    next_state_s = state_r;
                end else begin
                    next_state_s   = ST_GAP;
                    gap_cnt_next_s = GAP_LOAD;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r == '0) begin
                    next_state_s = req_s;
                end else begin
                    gap_cnt_next_s = gap_cnt_r - GAP_ONE;
                end
            end
            default: begin
                next_state_s   = ST_OFF;
                gap_cnt_next_s = '0;
            end
        endcase
    end

    // State and gap counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_OFF;
            gap_cnt_r <= '0;
        end else begin
            state_r   <= next_state_s;
            gap_cnt_r <= gap_cnt_next_s;
        end
    end

    // Outputs registered from the next state so they align with the state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            left_ena_r  <= 1'b0;
            right_ena_r <= 1'b0;
            mode_r      <= MODE_OFF;
            conflict_r  <= 1'b0;
        end else begin
            left_ena_r  <= (next_state_s == ST_LEFT)  || (next_state_s == ST_HAZARD);
            right_ena_r <= (next_state_s == ST_RIGHT) || (next_state_s == ST_HAZARD);
            mode_r      <= state_mode(next_state_s);
            conflict_r  <= conflict_s;
        end
    end

    assign bus.left_ena  = left_ena_r;
    assign bus.right_ena = right_ena_r;
    assign bus.mode      = mode_r;
    assign bus.conflict  = conflict_r;

endmodule

// File: tb/tb_turn_signal_ctrl.sv
// Directed, table-driven bench for turn_signal_ctrl with DEBOUNCE_CYCLES=4, MIN_OFF=3.
// Expected vector layout: {left_ena, right_ena, mode[1:0], conflict}.
module tb_turn_signal_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    turn_signal_ctrl_if bus ();

    turn_signal_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .MIN_OFF         (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic       l;
        logic       r;
        logic       h;
        int         cycles;
        logic [4:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic l, input logic r, input logic h,
                       input int cycles, input logic [4:0] exp, input string name);
        vec_t v;
        v.l = l; v.r = r; v.h = h; v.cycles = cycles; v.exp = exp; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [4:0] exp);
        logic [4:0] act;
        act = {bus.left_ena, bus.right_ena, bus.mode, bus.conflict};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got l/r/mode/conf=%b required %b at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.sw_left = 1'b0;
        bus.sw_right = 1'b0;
        bus.sw_hazard = 1'b0;

        // Left on/off latency, 7 clocks each way
        add(1'b0, 1'b0, 1'b0, 2, 5'b00000, "idle");
        add(1'b1, 1'b0, 1'b0, 6, 5'b00000, "left_before_7");
        add(1'b1, 1'b0, 1'b0, 1, 5'b10010, "left_at_7");
        add(1'b0, 1'b0, 1'b0, 6, 5'b10010, "left_rel_before_7");
        add(1'b0, 1'b0, 1'b0, 1, 5'b00000, "left_rel_at_7");
        add(1'b0, 1'b0, 1'b0, 5, 5'b00000, "settle_off1");
        // Glitch of 3 cycles is swallowed; a held switch is accepted
        add(1'b0, 1'b1, 1'b0, 3, 5'b00000, "glitch_high");
        add(1'b0, 1'b0, 1'b0, 10, 5'b00000, "glitch_after");
        add(1'b0, 1'b1, 1'b0, 6, 5'b00000, "right_before_7");
        add(1'b0, 1'b1, 1'b0, 1, 5'b01100, "right_at_7");
        add(1'b0, 1'b0, 1'b0, 7, 5'b00000, "right_off");
        add(1'b0, 1'b0, 1'b0, 5, 5'b00000, "settle_off2");
        // Left then hazard: exactly 3 gap cycles with both enables low
        add(1'b1, 1'b0, 1'b0, 7, 5'b10010, "left_on2");
        add(1'b1, 1'b0, 1'b1, 6, 5'b10010, "hz_before_gap");
        add(1'b1, 1'b0, 1'b1, 1, 5'b00000, "gap_1");
        add(1'b1, 1'b0, 1'b1, 1, 5'b00000, "gap_2");
        add(1'b1, 1'b0, 1'b1, 1, 5'b00000, "gap_3");
        add(1'b1, 1'b0, 1'b1, 1, 5'b11110, "hazard_on");
        // Conflict: both turns without hazard, then hazard overrides
        add(1'b1, 1'b1, 1'b0, 7, 5'b00001, "conflict_gap");
        add(1'b1, 1'b1, 1'b0, 5, 5'b00001, "conflict_off");
        add(1'b1, 1'b1, 1'b1, 7, 5'b11110, "conflict_hazard");

        // Reset held: switch activity must not reach the outputs
        repeat (2) @(negedge clk);
        check("rst_init", 5'b00000);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.sw_left = ~bus.sw_left;
            check("rst_hold", 5'b00000);
        end
        bus.sw_left = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_steady", 5'b00000);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            bus.sw_left = vecs[i].l;
            bus.sw_right = vecs[i].r;
            bus.sw_hazard = vecs[i].h;
            repeat (vecs[i].cycles) @(posedge clk);
            @(negedge clk);
            check(vecs[i].name, vecs[i].exp);
        end

        // Async reset mid-hazard: enables drop before the next clock edge
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_drop", 5'b00000);
        repeat (2) @(negedge clk);
        check("async_rst_hold", 5'b00000);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("post_rst_before_7", 5'b00000);
        @(posedge clk);
        @(negedge clk);
        check("post_rst_hazard", 5'b11110);

        // Drop hazard only: left+right remain, so hazard gaps into conflict OFF
        bus.sw_hazard = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("hazard_to_conflict", 5'b00001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/turn_signal_ctrl.md
# turn_signal_ctrl

Command front end for the tail-light sequencers: samples raw driver switches (left, right, hazard), synchronizes and debounces them, and arbitrates them into the `ena` inputs of the left and right LED sequencer FSMs. It guarantees a forced all-off gap whenever the active mode changes, so a sequencer always restarts from its idle pattern. Sits between the board switch pins and the two sequencer instances; runs on the same 1 kHz system clock.

## Interface
- `DEBOUNCE_CYCLES`, default 20: consecutive stable cycles required before a switch change is accepted (20 ms at 1 kHz); legal range ≥1.
- `MIN_OFF`, default 2: cycles both enables are held low on any mode change; legal range ≥1.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `sw_left` in 1: raw left-turn switch, asynchronous to `clk`.
- `sw_right` in 1: raw right-turn switch, asynchronous.
- `sw_hazard` in 1: raw hazard switch, asynchronous.
- `left_ena` out 1: enable to the left sequencer.
- `right_ena` out 1: enable to the right sequencer.
- `mode` out 2: current mode; 00 OFF, 01 LEFT, 10 RIGHT, 11 HAZARD.
- `conflict` out 1: high while debounced left and right are both high and hazard is low.

## Operation
- Each switch passes through a 2-flop synchronizer, then a debouncer. The debouncer's counter clears whenever the synchronized value equals the debounced value; otherwise it increments. On the edge where the count reaches `DEBOUNCE_CYCLES`, the debounced value takes the synchronized value and the counter clears.
- Request decode from debounced values, in priority order:
  - hazard → HAZARD;
  - left & right → OFF (`conflict`=1);
  - left → LEFT;
  - right → RIGHT;
  - otherwise → OFF.
- FSM states are OFF, LEFT, RIGHT, HAZARD and GAP.
  - OFF: if req≠OFF, go to req.
  - LEFT/RIGHT/HAZARD: if req equals the current state, stay. Otherwise go to GAP and load the gap counter with `MIN_OFF`−1.
  - GAP: if the counter is 0, go to req (possibly OFF). Otherwise decrement.
- Outputs are registered from the state:
  - LEFT: `left_ena`=1.
  - RIGHT: `right_ena`=1.
  - HAZARD: both enables = 1.
  - OFF and GAP: both enables = 0.
  - `mode` follows the state; GAP reports 00.
- A change of request that occurs during GAP does not restart the gap. The state at gap expiry is the request present on that edge.
- Width rules:
  - Debounce counter width is $clog2(`DEBOUNCE_CYCLES`+1).
  - Gap counter width is $clog2(`MIN_OFF`+1).
  - Neither counter wraps; both saturate by construction of the rules above.

## Timing
- Reset, asynchronous on `rst_n` low:
  - synchronizers, debounced values and all counters = 0;
  - state = OFF;
  - `left_ena`=`right_ena`=0, `mode`=00, `conflict`=0.
- Reset mid-blink drops the enables immediately, without waiting for a clock edge.
- After `rst_n` deasserts, the first effective edge is the next rising `clk`.
- Latency from a raw switch edge to the enable change (raw change set up before edge 0):
  - synchronizer: 2 cycles;
  - debounce: `DEBOUNCE_CYCLES` cycles;
  - FSM/output register: 1 cycle;
  - total: the enable changes on edge `DEBOUNCE_CYCLES`+2 (0-based), i.e. `DEBOUNCE_CYCLES`+3 clocks.
- A glitch shorter than `DEBOUNCE_CYCLES` synchronized cycles produces no output change.
- On a mode change from active to active (including LEFT↔HAZARD), both enables are low for exactly `MIN_OFF` cycles.
- From OFF to active there is no gap: one cycle after the debounced change.
- From active to OFF: enables fall 1 cycle after the debounced change. `mode` reads 00 from GAP onward.
- `conflict` is registered; it has the same 1-cycle latency as `mode`.
- Simultaneous debounced left and hazard rises resolve to HAZARD.

## Structure
- Shared package `taillight_pkg`: 2-bit mode encodings (MODE_OFF, MODE_LEFT, MODE_RIGHT, MODE_HAZARD) and the FSM state enum.
- The LED sequencers and the top level also use the mode encodings.
- Sub-module `sw_debounce`: synchronizer plus debouncer, parameter `DEBOUNCE_CYCLES`, ports clk/rst_n/raw/clean. It is instantiated three times.
- The FSM, gap counter and output registers live in `turn_signal_ctrl`.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `MIN_OFF`=3.
- Reset: with `rst_n` low, pulse `sw_left` → `left_ena`=`right_ena`=0, `mode`=00 throughout.
- Left on: `sw_left`=1 held → `left_ena` rises exactly 7 clocks after the first sampling edge, `mode`=01. Release → falls 7 clocks after release, `mode`=00.
- Glitch: `sw_right` high for 3 cycles, then low → no enable change. High for 4+ cycles → `right_ena`=1.
- Left→hazard while active: `sw_left`=1 steady, then `sw_hazard`=1 → `left_ena` low for exactly 3 cycles, then both enables = 1, `mode`=11.
- Conflict: `sw_left`=`sw_right`=1 → both enables 0, `conflict`=1, `mode`=00. Add `sw_hazard`=1 → `conflict`=0, both enables = 1.
- Async reset mid-HAZARD: drop `rst_n` between clock edges → both enables 0 before the next edge. After release, switches still high → enables return after 7 clocks.
